imm_extend_seq: RTL

IMM_EXTEND_SEQ -- requirements
Module: imm_extend_seq

---
 rtl/imm_extend_seq_pkg.sv | 20 ++
 rtl/imm_extend_seq_if.sv | 18 +
 rtl/imm_rotator.sv | 17 +
 rtl/imm_extend_seq.sv | 64 ++++++
 4 files changed

// File: rtl/imm_extend_seq_pkg.sv
// imm_extend_seq_pkg: shared encodings and defaults for the immediate extender
package imm_extend_seq_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ROT_STEP_DEF = 2;
  typedef enum logic [2:0] {
    SRC_IMM8  = 3'b000,
    SRC_IMM12 = 3'b001,
    SRC_BR    = 3'b010,
    SRC_MOV   = 3'b011,
    SRC_MOVT  = 3'b100,
    SRC_MOVM  = 3'b101,
    SRC_ROT   = 3'b110,
    SRC_ZERO  = 3'b111
  } imm_src_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/imm_extend_seq_if.sv
// imm_extend_seq_if: request/result handshake bundle for the immediate extender
interface imm_extend_seq_if
  import imm_extend_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic start;
  logic ready;
  logic [23:0] Instr;
  logic [2:0] ImmSrc;
  logic carry_in;
  logic [DATA_W-1:0] ExtImm;
  logic carry_out;
  logic valid;
  logic ack;
  modport master (output start, Instr, ImmSrc, carry_in, ack, input ready, ExtImm, carry_out, valid);
  modport slave (input start, Instr, ImmSrc, carry_in, ack, output ready, ExtImm, carry_out, valid);
endinterface

// File: rtl/imm_rotator.sv
// imm_rotator: 32-bit rotate right by 0..ROT_STEP bits
module imm_rotator
  import imm_extend_seq_pkg::*;
#(
  parameter int ROT_STEP = ROT_STEP_DEF
) (
  input  logic [31:0] din,
  input  logic [4:0]  amt,
  output logic [31:0] dout
);
  logic [4:0] sh;
  // clamp to the per-cycle limit, then rotate; a zero shift leaves the left term empty
  always_comb begin
    sh = amt > 5'(ROT_STEP) ? 5'(ROT_STEP) : amt;
    dout = (din >> sh) | (din << (6'd32 - {1'b0, sh}));
  end
endmodule

// File: rtl/imm_extend_seq.sv
// imm_extend_seq: multi-cycle immediate extender with iterative rotate
module imm_extend_seq
  import imm_extend_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROT_STEP = ROT_STEP_DEF
) (
  input logic clk,
  input logic reset,
  imm_extend_seq_if.slave bus
);
  state_e state_q, state_d;
  imm_src_e src;
  logic [DATA_W-1:0] res_q, pre;
  logic [4:0] rem_q, sh, amt;
  logic [31:0] rot_out;
  logic cq, accept;
  assign src = imm_src_e'(bus.ImmSrc);
  assign amt = {bus.Instr[11:8], 1'b0};
  assign accept = bus.start && bus.ready;
  assign sh = rem_q < 5'(ROT_STEP) ? rem_q : 5'(ROT_STEP);
  assign bus.ExtImm = res_q;
  assign bus.carry_out = cq;
  imm_rotator #(.ROT_STEP(ROT_STEP)) u_rot (.din(res_q[31:0]), .amt(sh), .dout(rot_out));
  // pre-rotation value selected by the mode at accept
  always_comb begin
    pre = (src == SRC_IMM8 || src == SRC_ROT) ? DATA_W'(bus.Instr[7:0]) :
          (src == SRC_IMM12 || src == SRC_MOV) ? DATA_W'(bus.Instr[11:0]) :
          (src == SRC_BR) ? {{(DATA_W-26){bus.Instr[23]}}, bus.Instr, 2'b00} :
          (src == SRC_MOVT) ? DATA_W'({bus.Instr[11:0], 16'h0}) :
          (src == SRC_MOVM) ? DATA_W'({bus.Instr[7:0], 12'h0}) : '0;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  // next state and handshake outputs
  always_comb begin
    state_d = state_q;
    bus.ready = state_q == IDLE;
    bus.valid = state_q == DONE;
    case (state_q)
      IDLE: if (accept) state_d = (src == SRC_ROT && amt != 5'd0) ? ROT : DONE;
      ROT: if (rem_q == sh) state_d = DONE;
      DONE: if (bus.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // result, remaining rotate count and carry; carry takes bit 31 on the last rotate step
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      res_q <= '0;
      rem_q <= '0;
      cq <= 1'b0;
    end else if (accept) begin
      res_q <= pre;
      rem_q <= src == SRC_ROT ? amt : 5'd0;
      cq <= bus.carry_in;
    end else if (state_q == ROT) begin
      res_q <= DATA_W'(rot_out);
      rem_q <= rem_q - sh;
      if (rem_q == sh) cq <= rot_out[31];
    end
endmodule
